payload_router: RTL and testbench

PAYLOAD_ROUTER -- requirements
Module: payload_router

---
 rtl/payload_router.sv | 107 ++++++++++
 tb/tb_payload_router.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/payload_router.sv
// Routes typed message beats into per-channel first-word-fall-through FIFOs.
// Beats with an unknown type are counted and discarded. Full channels either stall or drop.
module payload_router #(
  parameter int unsigned           NUM_CH       = 4,
  parameter int unsigned           PAYLOAD_W    = 512,
  parameter int unsigned           DEPTH        = 4,
  parameter logic [8*NUM_CH-1:0]   TYPE_CODES   = {"U", "D", "X", "A"},
  parameter bit                    DROP_ON_FULL = 1'b0
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [7:0]                              msg_type,
  input  logic [PAYLOAD_W-1:0]                    payload,
  output logic [NUM_CH-1:0]                       out_valid,
  input  logic [NUM_CH-1:0]                       out_ready,
  output logic [NUM_CH*PAYLOAD_W-1:0]             out_payload,
  output logic [NUM_CH*($clog2(DEPTH)+1)-1:0]     ch_level,
  output logic [15:0]                             unknown_cnt,
  output logic [15:0]                             drop_cnt
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned LvlW  = AddrW + 1;
  localparam logic [LvlW-1:0] FullLvl = LvlW'(DEPTH);

  logic [PAYLOAD_W-1:0] mem_q    [NUM_CH][DEPTH];
  logic [AddrW-1:0]     wr_ptr_q [NUM_CH];
  logic [AddrW-1:0]     rd_ptr_q [NUM_CH];
  logic [LvlW-1:0]      level_q  [NUM_CH];

  logic [NUM_CH-1:0] tgt, full, push, pop;
  logic              any_hit, tgt_full, accept;
  logic [15:0]       unknown_q, unknown_d, drop_q, drop_d;

  // Priority decode: the lowest-index matching channel wins.
  always_comb begin
    tgt     = '0;
    full    = '0;
    any_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      full[i] = (level_q[i] == FullLvl);
      if (!any_hit && (msg_type == TYPE_CODES[8*i +: 8])) begin
        tgt[i]  = 1'b1;
        any_hit = 1'b1;
      end
    end
    tgt_full = |(tgt & full);
    // Depends only on full flags and msg_type, so no path from out_ready.
    in_ready = rst_n && !(!DROP_ON_FULL && tgt_full);
    accept   = in_valid && in_ready;
    push     = accept ? (tgt & ~full) : '0;
  end

  always_comb begin
    out_valid   = '0;
    out_payload = '0;
    ch_level    = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      out_valid[i]                          = (level_q[i] != '0);
      out_payload[PAYLOAD_W*i +: PAYLOAD_W] = mem_q[i][rd_ptr_q[i]];
      ch_level[LvlW*i +: LvlW]              = level_q[i];
    end
    pop = out_valid & out_ready;
  end

  always_comb begin
    unknown_d = unknown_q;
    drop_d    = drop_q;
    if (accept && !any_hit && (unknown_q != 16'hFFFF)) unknown_d = unknown_q + 16'd1;
    if (accept && tgt_full && (drop_q != 16'hFFFF))    drop_d    = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        level_q[i]  <= '0;
      end
      unknown_q <= '0;
      drop_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + AddrW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + AddrW'(1);
        if (push[i] != pop[i]) begin
          level_q[i] <= push[i] ? level_q[i] + LvlW'(1) : level_q[i] - LvlW'(1);
        end
      end
      unknown_q <= unknown_d;
      drop_q    <= drop_d;
    end
  end

  // Storage needs no reset; push is already gated off while rst_n is low.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= payload;
    end
  end

  assign unknown_cnt = unknown_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_payload_router.sv
// Bench for payload_router: one stalling and one dropping instance share the same stimulus,
// each tracked by a queue-based model, plus directed vectors and corner sequences.
module tb_payload_router;

  localparam int NCH = 4;
  localparam int PW  = 32;
  localparam int DEP = 4;
  localparam int LW  = 3;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic [7:0]     msg_type = 8'h00;
  logic [PW-1:0]  payload = '0;
  logic [NCH-1:0] out_ready = '0;

  logic               in_ready_m    [2];
  logic [NCH-1:0]     out_valid_m   [2];
  logic [NCH*PW-1:0]  out_payload_m [2];
  logic [NCH*LW-1:0]  ch_level_m    [2];
  logic [15:0]        unknown_m     [2];
  logic [15:0]        drop_m        [2];

  int checks = 0;
  int errors = 0;

  // Reference state: index 0 = backpressure instance, 1 = drop instance.
  logic [PW-1:0] mq [2][NCH][$];
  int unsigned   unk_e [2];
  int unsigned   drp_e [2];

  always #5 clk = ~clk;

  payload_router #(.NUM_CH(NCH), .PAYLOAD_W(PW), .DEPTH(DEP), .DROP_ON_FULL(1'b0)) dut_bp (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m[0]),
    .msg_type(msg_type), .payload(payload), .out_valid(out_valid_m[0]),
    .out_ready(out_ready), .out_payload(out_payload_m[0]), .ch_level(ch_level_m[0]),
    .unknown_cnt(unknown_m[0]), .drop_cnt(drop_m[0])
  );

  payload_router #(.NUM_CH(NCH), .PAYLOAD_W(PW), .DEPTH(DEP), .DROP_ON_FULL(1'b1)) dut_drop (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m[1]),
    .msg_type(msg_type), .payload(payload), .out_valid(out_valid_m[1]),
    .out_ready(out_ready), .out_payload(out_payload_m[1]), .ch_level(ch_level_m[1]),
    .unknown_cnt(unknown_m[1]), .drop_cnt(drop_m[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int tgt_of(input logic [7:0] mt);
    case (mt)
      "A":     return 0;
      "X":     return 1;
      "D":     return 2;
      "U":     return 3;
      default: return -1;
    endcase
  endfunction

  function automatic bit m_rdy(input int m);
    int t;
    if (rst_n !== 1'b1) return 1'b0;
    t = tgt_of(msg_type);
    if (m == 0 && t >= 0 && mq[m][t].size() == DEP) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_model();
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) mq[m][c].delete();
      unk_e[m] = 0;
      drp_e[m] = 0;
    end
  endtask

  task automatic compare_all(input string tag);
    int sz;
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("%s in_ready[%0d]", tag, m), in_ready_m[m], m_rdy(m));
      for (int c = 0; c < NCH; c++) begin
        sz = mq[m][c].size();
        chk($sformatf("%s out_valid[%0d][%0d]", tag, m, c), out_valid_m[m][c], sz != 0);
        chk($sformatf("%s ch_level[%0d][%0d]", tag, m, c), ch_level_m[m][LW*c +: LW], sz);
        if (sz != 0)
          chk($sformatf("%s head[%0d][%0d]", tag, m, c), out_payload_m[m][PW*c +: PW],
              mq[m][c][0]);
      end
      chk($sformatf("%s unknown_cnt[%0d]", tag, m), unknown_m[m], unk_e[m]);
      chk($sformatf("%s drop_cnt[%0d]", tag, m), drop_m[m], drp_e[m]);
    end
  endtask

  // Checks against the model, applies one rising edge, and updates the model.
  task automatic step(input string tag);
    int            t;
    bit            acc  [2];
    bit            full [2];
    bit            popb [2][NCH];
    logic [PW-1:0] pl;
    #1;
    compare_all(tag);
    t  = tgt_of(msg_type);
    pl = payload;
    for (int m = 0; m < 2; m++) begin
      acc[m]  = in_valid && m_rdy(m);
      full[m] = (t >= 0) && (mq[m][t].size() == DEP);
      for (int c = 0; c < NCH; c++) popb[m][c] = (mq[m][c].size() != 0) && out_ready[c];
    end
    @(posedge clk);
    for (int m = 0; m < 2; m++) begin
      for (int c = 0; c < NCH; c++) if (popb[m][c]) void'(mq[m][c].pop_front());
      if (acc[m]) begin
        if (t < 0) begin
          if (unk_e[m] < 16'hFFFF) unk_e[m]++;
        end else if (full[m]) begin
          if (drp_e[m] < 16'hFFFF) drp_e[m]++;
        end else begin
          mq[m][t].push_back(pl);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    clear_model();
    compare_all("reset");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    compare_all("post-reset");
  endtask

  typedef struct {
    bit             v;
    logic [7:0]     mt;
    logic [PW-1:0]  pl;
    logic [NCH-1:0] ordy;
    bit             exp_rdy;
    logic [NCH-1:0] exp_ov;
    logic [PW-1:0]  exp_pl;
    logic [15:0]    exp_unk;
  } vec_t;

  vec_t       tbl [6];
  logic [7:0] codes [5];
  int         k;
  int         sel;
  bit         accepted;

  initial begin
    codes = '{"A", "X", "D", "U", "E"};
    tbl[0] = '{1'b1, "A", 32'h1111_0001, 4'hF, 1'b1, 4'b0001, 32'h1111_0001, 16'd0};
    tbl[1] = '{1'b1, "X", 32'h2222_0002, 4'hF, 1'b1, 4'b0010, 32'h2222_0002, 16'd0};
    tbl[2] = '{1'b1, "D", 32'h3333_0003, 4'hF, 1'b1, 4'b0100, 32'h3333_0003, 16'd0};
    tbl[3] = '{1'b1, "U", 32'h4444_0004, 4'hF, 1'b1, 4'b1000, 32'h4444_0004, 16'd0};
    tbl[4] = '{1'b0, "A", 32'h0,         4'hF, 1'b1, 4'b0000, 32'h0,         16'd0};
    tbl[5] = '{1'b1, "E", 32'h5555_0005, 4'hF, 1'b1, 4'b0000, 32'h0,         16'd1};

    clear_model();
    #1;
    compare_all("in-reset");
    chk("reset in_ready low", in_ready_m[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic routing and unknown type.
    foreach (tbl[i]) begin
      in_valid  = tbl[i].v;
      msg_type  = tbl[i].mt;
      payload   = tbl[i].pl;
      out_ready = tbl[i].ordy;
      #1;
      chk($sformatf("tbl%0d in_ready", i), in_ready_m[0], tbl[i].exp_rdy);
      step("tbl");
      chk($sformatf("tbl%0d out_valid", i), out_valid_m[0], tbl[i].exp_ov);
      for (int c = 0; c < NCH; c++)
        if (tbl[i].exp_ov[c])
          chk($sformatf("tbl%0d payload", i), out_payload_m[0][PW*c +: PW], tbl[i].exp_pl);
      chk($sformatf("tbl%0d unknown_cnt", i), unknown_m[0], tbl[i].exp_unk);
    end
    in_valid = 1'b0;

    // Backpressure vs drop on a full channel.
    do_reset();
    out_ready = '0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      msg_type = "A";
      payload  = 32'hA000_0000 + 32'(i);
      step("fill");
    end
    chk("bp ch_level0 full", ch_level_m[0][2:0], 3'd4);
    chk("drop ch_level0 full", ch_level_m[1][2:0], 3'd4);
    payload = 32'hA000_0004;
    #1;
    chk("bp fifth in_ready", in_ready_m[0], 1'b0);
    chk("drop fifth in_ready", in_ready_m[1], 1'b1);
    step("fifth");
    chk("drop drop_cnt", drop_m[1], 16'd1);
    chk("bp drop_cnt", drop_m[0], 16'd0);
    msg_type = "X";
    payload  = 32'hB000_0000;
    #1;
    chk("bp X while ch0 full", in_ready_m[0], 1'b1);
    step("other-ch");
    chk("bp ch_level1", ch_level_m[0][5:3], 3'd1);
    msg_type  = "A";
    payload   = 32'hA000_0004;
    out_ready = 4'b0001;
    #1;
    chk("bp still stalled on release", in_ready_m[0], 1'b0);
    k = 0;
    for (int cyc = 0; cyc < 12 && k < 5; cyc++) begin
      #1;
      if (out_valid_m[0][0]) begin
        chk($sformatf("drain order %0d", k), out_payload_m[0][31:0], 32'hA000_0000 + 32'(k));
        k++;
      end
      accepted = in_valid && in_ready_m[0];
      step("drain");
      if (accepted) in_valid = 1'b0;
    end
    chk("drain count", k, 5);
    in_valid = 1'b0;

    // Simultaneous push and pop on a partly filled channel.
    do_reset();
    out_ready = '0;
    in_valid  = 1'b1;
    msg_type  = "X";
    payload   = 32'hC000_0001;
    step("pp-fill");
    payload = 32'hC000_0002;
    step("pp-fill");
    chk("pp level before", ch_level_m[0][5:3], 3'd2);
    payload   = 32'hC000_0003;
    out_ready = 4'b0010;
    #1;
    chk("pp head R1", out_payload_m[0][63:32], 32'hC000_0001);
    step("pp");
    chk("pp level after", ch_level_m[0][5:3], 3'd2);
    chk("pp head R2", out_payload_m[0][63:32], 32'hC000_0002);
    in_valid = 1'b0;
    step("pp-drain");
    chk("pp head R3", out_payload_m[0][63:32], 32'hC000_0003);
    step("pp-drain");
    chk("pp empty", out_valid_m[0][1], 1'b0);

    // Reset asserted with entries buffered.
    do_reset();
    out_ready = '0;
    in_valid  = 1'b1;
    foreach (codes[i]) begin
      if (i == 3) continue;
      msg_type = codes[i];
      payload  = 32'hD000_0000 + 32'(i);
      step("mid-fill");
    end
    in_valid = 1'b0;
    chk("mid unknown before", unknown_m[0], 16'd1);
    #2;
    rst_n = 1'b0;
    #1;
    clear_model();
    for (int m = 0; m < 2; m++) begin
      chk($sformatf("mid out_valid[%0d]", m), out_valid_m[m], 4'b0000);
      chk($sformatf("mid ch_level[%0d]", m), ch_level_m[m], 12'h000);
      chk($sformatf("mid unknown[%0d]", m), unknown_m[m], 16'd0);
      chk($sformatf("mid drop[%0d]", m), drop_m[m], 16'd0);
      chk($sformatf("mid in_ready[%0d]", m), in_ready_m[m], 1'b0);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    msg_type = "D";
    payload  = 32'hE000_0001;
    #1;
    chk("post-rst in_ready", in_ready_m[0], 1'b1);
    step("post-rst");
    chk("post-rst out_valid", out_valid_m[0], 4'b0100);
    chk("post-rst payload", out_payload_m[0][95:64], 32'hE000_0001);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      sel       = int'($urandom_range(0, 5));
      msg_type  = (sel < 5) ? codes[sel] : 8'($urandom_range(0, 255));
      payload   = $urandom;
      out_ready = 4'($urandom);
      if ($urandom_range(0, 399) == 0) do_reset();
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
